// File: rtl/avalon_timer_pkg.sv
// Shared constants and types for the Avalon interval timer.
// Optional watchdog on channel 0: AVALON_TIMER_WATCHDOG_EN.
package avalon_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;
  localparam logic [2:0] REG_IRQPEND = 3'd6;
  localparam logic [2:0] REG_KICK    = 3'd7;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_WDEN  = 4;

  typedef struct packed {
`ifdef AVALON_TIMER_WATCHDOG_EN
    logic wden;
`endif
    logic cont;
    logic ito;
    logic run;
    logic to;
  } ch_flags_t;

  typedef struct packed {
`ifdef AVALON_TIMER_WATCHDOG_EN
    logic kick_wr;
`endif
    logic status_wr;
    logic ctrl_wr;
    logic perl_wr;
    logic perh_wr;
    logic snap_wr;
  } ch_cmd_t;

endpackage

// File: rtl/avalon_interval_timer_ex_channel.sv
// One down-counting timer channel: counter, period, snapshot, flags.
// With AVALON_TIMER_WATCHDOG_EN it also owns WDEN and the reset pulse.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h004C4B3F
`ifdef AVALON_TIMER_WATCHDOG_EN
  ,
  parameter bit          HAS_WDT      = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  ch_cmd_t          cmd,
  input  logic [15:0]      wdata,
  output ch_flags_t        flags,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap
`ifdef AVALON_TIMER_WATCHDOG_EN
  ,
  output logic             wdt_pulse
`endif
);

  localparam int HI_W = CNT_W - 16;
  localparam logic [CNT_W-1:0] RST_LOAD = RESET_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_nx;
  logic             zero_hit;
  logic             reload;

  assign zero_hit = flags.run && (cnt == '0);

`ifdef AVALON_TIMER_WATCHDOG_EN
  assign reload = cmd.perl_wr || cmd.perh_wr || cmd.kick_wr;
`else
  assign reload = cmd.perl_wr || cmd.perh_wr;
`endif

  // Merge a PERIODL/PERIODH write into the current period.
  always_comb begin
    period_nx = period;
    if (cmd.perl_wr) period_nx[15:0] = wdata;
    if (cmd.perh_wr) period_nx[CNT_W-1:16] = wdata[HI_W-1:0];
  end

  // Counter, period and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= RST_LOAD;
      period <= RST_LOAD;
      snap   <= '0;
    end else begin
      period <= period_nx;
      if (reload)        cnt <= period_nx;
      else if (zero_hit) cnt <= period;
      else if (flags.run) cnt <= cnt - ONE;
      if (cmd.snap_wr) snap <= cnt;
    end
  end

  // Status/control flags; a timeout beats a same-cycle clear, STOP beats START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else begin
      if (zero_hit)           flags.to <= 1'b1;
      else if (cmd.status_wr) flags.to <= 1'b0;
      if (cmd.ctrl_wr && wdata[CTL_STOP])
        flags.run <= 1'b0;
      else if (cmd.ctrl_wr && wdata[CTL_START])
        flags.run <= 1'b1;
      else if (zero_hit && !flags.cont)
        flags.run <= 1'b0;
      if (cmd.ctrl_wr) begin
        flags.ito  <= wdata[CTL_ITO];
        flags.cont <= wdata[CTL_CONT];
      end
`ifdef AVALON_TIMER_WATCHDOG_EN
      if (HAS_WDT && cmd.ctrl_wr && wdata[CTL_WDEN])
        flags.wden <= 1'b1;
`endif
    end
  end

`ifdef AVALON_TIMER_WATCHDOG_EN
  // One-cycle reset request on a timeout while the watchdog is armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdt_pulse <= 1'b0;
    else          wdt_pulse <= zero_hit && flags.wden;
  end
`endif

endmodule

// File: rtl/avalon_interval_timer_ex.sv
// Avalon-MM multi-channel interval timer: decode, read mux, irq OR.
// Optional watchdog on channel 0: AVALON_TIMER_WATCHDOG_EN.
module avalon_interval_timer_ex
  import avalon_timer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h004C4B3F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
`ifdef AVALON_TIMER_WATCHDOG_EN
  ,
  output logic        wdt_reset_req
`endif
);

  localparam int HI_W = CNT_W - 16;

  logic [1:0]       ch_sel;
  logic [2:0]       reg_sel;
  logic             wr;
  logic             rd;
  logic [15:0]      rd_mux;
  logic [NUM_CH-1:0] pend;

  ch_cmd_t          cmd        [NUM_CH];
  ch_flags_t        flags      [NUM_CH];
  logic [CNT_W-1:0] period_arr [NUM_CH];
  logic [CNT_W-1:0] snap_arr   [NUM_CH];
`ifdef AVALON_TIMER_WATCHDOG_EN
  logic [NUM_CH-1:0] wdt_vec;
`endif

  assign ch_sel  = address[4:3];
  assign reg_sel = address[2:0];
  assign wr      = chipselect && !write_n;
  assign rd      = chipselect && !read_n;

  // Per-channel write strobes; unmatched channel numbers are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cmd[i] = '0;
      if (wr && ch_sel == 2'(i)) begin
        unique case (1'b1)
          reg_sel == REG_STATUS:  cmd[i].status_wr = 1'b1;
          reg_sel == REG_CONTROL: cmd[i].ctrl_wr   = 1'b1;
          reg_sel == REG_PERIODL: cmd[i].perl_wr   = 1'b1;
          reg_sel == REG_PERIODH: cmd[i].perh_wr   = 1'b1;
          reg_sel == REG_SNAPL:   cmd[i].snap_wr   = 1'b1;
          reg_sel == REG_SNAPH:   cmd[i].snap_wr   = 1'b1;
`ifdef AVALON_TIMER_WATCHDOG_EN
          reg_sel == REG_KICK:    cmd[i].kick_wr   = (i == 0);
`endif
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
`ifdef AVALON_TIMER_WATCHDOG_EN
      ,
      .HAS_WDT      (g == 0)
`endif
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd     (cmd[g]),
      .wdata   (writedata),
      .flags   (flags[g]),
      .period  (period_arr[g]),
      .snap    (snap_arr[g])
`ifdef AVALON_TIMER_WATCHDOG_EN
      ,
      .wdt_pulse (wdt_vec[g])
`endif
    );
  end

  // Pending interrupts and their OR onto the CPU line.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      pend[i] = flags[i].to && flags[i].ito;
    irq = |pend;
  end

`ifdef AVALON_TIMER_WATCHDOG_EN
  assign wdt_reset_req = |wdt_vec;
`endif

  // Read mux; IRQPEND ignores the channel field, absent channels read 0.
  always_comb begin
    rd_mux = '0;
    if (reg_sel == REG_IRQPEND) begin
      rd_mux[NUM_CH-1:0] = pend;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 2'(i)) begin
          unique case (1'b1)
            reg_sel == REG_STATUS:
              rd_mux[1:0] = {flags[i].run, flags[i].to};
            reg_sel == REG_CONTROL:
              rd_mux[1:0] = {flags[i].cont, flags[i].ito};
            reg_sel == REG_PERIODL:
              rd_mux = period_arr[i][15:0];
            reg_sel == REG_PERIODH:
              rd_mux[HI_W-1:0] = period_arr[i][CNT_W-1:16];
            reg_sel == REG_SNAPL:
              rd_mux = snap_arr[i][15:0];
            reg_sel == REG_SNAPH:
              rd_mux[HI_W-1:0] = snap_arr[i][CNT_W-1:16];
            default: ;
          endcase
        end
      end
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  readdata <= '0;
    else if (rd)   readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avalon_interval_timer_ex.sv
// Directed + randomized bench for avalon_interval_timer_ex.
// Watchdog steps are included when AVALON_TIMER_WATCHDOG_EN is defined.
module tb_avalon_interval_timer_ex;

  localparam int R_STATUS = 0, R_CONTROL = 1, R_PERL = 2, R_PERH = 3;
  localparam int R_SNAPL = 4, R_SNAPH = 5, R_PEND = 6, R_KICK = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
`ifdef AVALON_TIMER_WATCHDOG_EN
  logic        wdt_reset_req;
  int          wdt_cnt = 0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_edge = 0;

  avalon_interval_timer_ex #(
    .NUM_CH(2), .CNT_W(32), .RESET_PERIOD(32'h004C4B3F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
`ifdef AVALON_TIMER_WATCHDOG_EN
    ,
    .wdt_reset_req (wdt_reset_req)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef AVALON_TIMER_WATCHDOG_EN
  always @(negedge clk) if (wdt_reset_req === 1'b1) wdt_cnt <= wdt_cnt + 1;
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(int ch, int rg, logic [15:0] d);
    @(negedge clk);
    address = 5'(ch * 8 + rg);
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
    last_edge = cyc;
  endtask

  task automatic rd(int ch, int rg, output logic [15:0] d);
    @(negedge clk);
    address = 5'(ch * 8 + rg);
    chipselect = 1'b1;
    read_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n = 1'b1;
    d = readdata;
    last_edge = cyc;
  endtask

  task automatic wait_edge(int e);
    vectors++;
    assert (cyc <= e) else begin
      miscompares++;
      $error("FAIL sched: observed edge %0d expected <= %0d", cyc, e);
    end
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: timeout edges of a continuous channel started at es.
  function automatic int to_edge(int es, int p, int n);
    return es + n * (p + 1);
  endfunction

  initial begin
    logic [15:0] d;
    logic [31:0] p, exp;
    int es, ew, dly, ch;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
`ifdef AVALON_TIMER_WATCHDOG_EN
    check("rst_wdt", wdt_reset_req, 0);
`endif
    rd(0, R_PERL, d);    check("rst_perl", d, 16'h4B3F);
    rd(0, R_PERH, d);    check("rst_perh", d, 16'h004C);
    rd(0, R_STATUS, d);  check("rst_status", d, 0);
    rd(1, R_CONTROL, d); check("rst_control", d, 0);
    rd(1, R_SNAPL, d);   check("rst_snapl", d, 0);

    // continuous ch0, period 9, irq on
    wr(0, R_PERL, 16'd9);
    wr(0, R_PERH, 16'd0);
    wr(0, R_CONTROL, 16'h7);
    es = last_edge;
    wait_edge(to_edge(es, 9, 1) - 1); check("c_irq_pre1", irq, 0);
    wait_edge(to_edge(es, 9, 1));     check("c_irq_to1", irq, 1);
    rd(0, R_PEND, d);   check("c_pend", d, 16'h1);
    rd(0, R_STATUS, d); check("c_status", d, 16'h3);
    rd(0, R_CONTROL, d); check("c_control", d, 16'h3);
    wr(0, R_STATUS, 16'h0);
    check("c_irq_clr", irq, 0);
    wait_edge(to_edge(es, 9, 2) - 1); check("c_irq_pre2", irq, 0);
    wait_edge(to_edge(es, 9, 2));     check("c_irq_to2", irq, 1);
    wr(0, R_CONTROL, 16'h8);
    wr(0, R_STATUS, 16'h0);
    check("c_irq_off", irq, 0);

    // one-shot ch1, period 4
    wr(1, R_PERL, 16'd4);
    wr(1, R_PERH, 16'd0);
    wr(1, R_CONTROL, 16'h4);
    es = last_edge;
    wait_edge(es + 3);
    rd(1, R_STATUS, d); check("os_st4", d, 16'h2);
    rd(1, R_STATUS, d); check("os_st5", d, 16'h2);
    rd(1, R_STATUS, d); check("os_st6", d, 16'h1);
    check("os_irq", irq, 0);
    repeat (7) @(posedge clk);
    wr(1, R_SNAPL, 16'h0);
    rd(1, R_SNAPL, d); check("os_hold_l", d, 16'd4);
    rd(1, R_SNAPH, d); check("os_hold_h", d, 16'd0);
    wr(1, R_STATUS, 16'h0);

    // snapshot mid-count at 0x00012345
    dly = $urandom_range(4, 20);
    p = 32'h00012345 + 32'(dly);
    wr(0, R_PERL, p[15:0]);
    wr(0, R_PERH, p[31:16]);
    wr(0, R_CONTROL, 16'h4);
    es = last_edge;
    repeat (dly) @(posedge clk);
    wr(0, R_SNAPH, 16'h0);
    ew = last_edge;
    exp = p - 32'(ew - 1 - es);
    rd(0, R_SNAPL, d); check("snap_l", d, exp[15:0]);
    rd(0, R_SNAPH, d); check("snap_h", d, exp[31:16]);
    repeat (10) @(posedge clk);
    rd(0, R_SNAPL, d); check("snap_l_stable", d, exp[15:0]);
    rd(0, R_SNAPH, d); check("snap_h_stable", d, exp[31:16]);
    wr(0, R_CONTROL, 16'h8);

    // status clear in the timeout cycle, then START+STOP
    wr(0, R_PERL, 16'd5);
    wr(0, R_PERH, 16'd0);
    wr(0, R_CONTROL, 16'h6);
    es = last_edge;
    wait_edge(es + 5);
    wr(0, R_STATUS, 16'h0);
    rd(0, R_STATUS, d); check("to_race", d, 16'h3);
    wr(0, R_CONTROL, 16'h8);
    wr(0, R_STATUS, 16'h0);
    wr(0, R_CONTROL, 16'hC);
    rd(0, R_STATUS, d); check("start_stop", d, 16'h0);

    // absent channels and reg 7
    wr(3, R_PERL, 16'h1234);
    rd(3, R_PERL, d);   check("oor_perl", d, 0);
    rd(2, R_STATUS, d); check("oor_status", d, 0);
    rd(0, R_KICK, d);   check("reg7", d, 0);

    // randomized continuous runs
    for (int it = 0; it < 4; it++) begin
      p = 32'($urandom_range(3, 30));
      ch = int'($urandom_range(0, 1));
      wr(ch, R_PERL, p[15:0]);
      wr(ch, R_PERH, 16'h0);
      wr(ch, R_CONTROL, 16'h7);
      es = last_edge;
      for (int n = 1; n <= 2; n++) begin
        wait_edge(to_edge(es, int'(p), n) - 1);
        check("r_irq_pre", irq, 0);
        wait_edge(to_edge(es, int'(p), n));
        check("r_irq_to", irq, 1);
        rd(ch, R_PEND, d);
        check("r_pend", d, 16'(1 << ch));
        wr(ch, R_STATUS, 16'h0);
      end
      wr(ch, R_CONTROL, 16'h8);
      wr(ch, R_STATUS, 16'h0);
      check("r_irq_off", irq, 0);
    end

`ifdef AVALON_TIMER_WATCHDOG_EN
    // watchdog timeout without kicks, then kicked
    wr(0, R_PERL, 16'd7);
    wr(0, R_PERH, 16'd0);
    wr(0, R_STATUS, 16'h0);
    wr(0, R_CONTROL, 16'h16);
    es = last_edge;
    wait_edge(es + 7); check("wdt_pre", wdt_reset_req, 0);
    wait_edge(es + 8); check("wdt_pulse", wdt_reset_req, 1);
    wait_edge(es + 9); check("wdt_post", wdt_reset_req, 0);
    wdt_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      wr(0, R_KICK, 16'h0);
      repeat (4) @(posedge clk);
    end
    wr(0, R_CONTROL, 16'h8);
    #1;
    check("wdt_kicked", 32'(wdt_cnt), 0);
    rd(0, R_KICK, d); check("wdt_reg7", d, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
